// File: rtl/riscv_pkg.sv
// Shared RV32I constants: funct3 width/sign codes and load/store unit state encodings.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_BUSY = 2'd1;
    localparam logic [1:0] LSU_DONE = 2'd2;

    // Stores only have byte/half/word; loads additionally have the unsigned byte/half forms.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3 > F3_W;
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte enables/replication, access checks, load extract/extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    assign illegal    = f3_illegal(is_store, funct3);

    // Data is replicated across lanes so the enabled lane always carries the right bytes.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (funct3)
                F3_B: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                F3_W:    be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    always_comb begin
        load_ext = 32'd0;
        case (funct3)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_ext = rdata;
            F3_BU:   load_ext = {24'd0, byte_sel};
            F3_HU:   load_ext = {16'd0, half_sel};
            default: load_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: request FSM, capture registers and bus-timeout counter.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;

    logic        al_is_store;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misaligned;
    logic        al_illegal;
    logic [31:0] al_load_ext;

    // One aligner serves both phases: live inputs while deciding in IDLE, captured fields afterwards.
    assign al_is_store = (state == LSU_IDLE) ? is_store     : is_store_q;
    assign al_funct3   = (state == LSU_IDLE) ? funct3       : funct3_q;
    assign al_addr_lo  = (state == LSU_IDLE) ? addr[1:0]    : addr_lo_q;

    lsu_align u_align (
        .is_store   (al_is_store),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal),
        .load_ext   (al_load_ext)
    );

    assign stall = !rst && (((state == LSU_IDLE) && req_valid) || (state == LSU_BUSY));
    assign done  = !rst && (state == LSU_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LSU_IDLE;
            cnt        <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            fault      <= 1'b0;
            load_data  <= 32'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    cnt       <= '0;
                    fault     <= 1'b0;
                    load_data <= 32'd0;
                    if (req_valid) begin
                        if (al_misaligned || al_illegal) begin
                            state <= LSU_DONE;
                            fault <= 1'b1;
                        end else begin
                            state      <= LSU_BUSY;
                            is_store_q <= is_store;
                            funct3_q   <= funct3;
                            addr_lo_q  <= addr[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= al_be;
                            dmem_wdata <= al_wdata;
                        end
                    end
                end
                LSU_BUSY: begin
                    if (dmem_ready) begin
                        state     <= LSU_DONE;
                        dmem_req  <= 1'b0;
                        fault     <= 1'b0;
                        load_data <= is_store_q ? 32'd0 : al_load_ext;
                    end else if (cnt == CNT_LAST) begin
                        state     <= LSU_DONE;
                        dmem_req  <= 1'b0;
                        fault     <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LSU_DONE: begin
                    state     <= LSU_IDLE;
                    fault     <= 1'b0;
                    load_data <= 32'd0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model, per-cycle compare, directed and random accesses.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        txn_active = 1'b0;
    logic        idle_chk   = 1'b0;
    int          k          = 0;
    int          txn_id     = 0;
    int          n_busy     = 0;
    logic        exp_st;
    logic        exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_load;
    int          stall_cnt;
    int          done_k;
    logic [31:0] last_load;
    logic        last_fault;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s (txn %0d, cycle %0d): got %h, expected %h", name, txn_id, k, act, exp);
    endtask

    // Reference behaviour of one access from the ISA rules: sizes in bytes, offsets, masks.
    function automatic void model_eval(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] rd,
                                       output logic bad, output logic [3:0] be,
                                       output logic [31:0] wd, output logic [31:0] ld);
        int          nbytes;
        int          off;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] val;
        off    = int'(a % 4);
        legal  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = legal ? (1 << f3[1:0]) : 1;
        bad    = !legal || ((off % nbytes) != 0);
        be     = st ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++)
            wd[8*i +: 8] = d[8*(i % nbytes) +: 8];
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val  = (rd >> (8 * off)) & mask;
        if (!f3[2] && (nbytes < 4) && val[8*nbytes-1])
            val = val | ~mask;
        ld = (st || bad) ? 32'd0 : val;
    endfunction

    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input int ready_at);
        logic        bad;
        logic        tmo;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        model_eval(st, f3, a, d, rd, bad, be, wd, ld);
        tmo       = !bad && !((ready_at >= 1) && (ready_at <= 16));
        n_busy    = bad ? 0 : (tmo ? 16 : ready_at);
        exp_st    = st;
        exp_be    = be;
        exp_wdata = wd;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_fault = bad || tmo;
        exp_load  = exp_fault ? 32'd0 : ld;
        @(posedge clk); #1;
        txn_id++;
        stall_cnt  = 0;
        done_k     = -1;
        k          = 0;
        txn_active = 1'b1;
        req_valid  = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        dmem_ready = 1'($urandom % 2);
        dmem_rdata = $urandom;
        for (int c = 1; c <= n_busy + 1; c++) begin
            @(posedge clk); #1;
            k          = c;
            addr       = $urandom;
            store_data = $urandom;
            if (c <= n_busy) begin
                dmem_ready = (c == ready_at);
                dmem_rdata = (c == ready_at) ? rd : $urandom;
            end else begin
                dmem_ready = 1'($urandom % 2);
                dmem_rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        txn_active = 1'b0;
        req_valid  = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic apply_stimulus(input int n);
        logic [2:0]  f3;
        logic [31:0] a;
        logic        st;
        int          ra;
        for (int i = 0; i < n; i++) begin
            st = 1'($urandom % 2);
            if ($urandom % 10 == 0)
                f3 = 3'($urandom % 8);
            else if (st)
                f3 = 3'($urandom % 3);
            else
                f3 = 3'($urandom_range(0, 4) + (($urandom_range(0, 4) > 2) ? 2 : 0)) & 3'b111;
            a = $urandom;
            if ($urandom % 2 == 0)
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            case ($urandom % 12)
                0:       ra = 0;
                1:       ra = 16;
                2:       ra = 17;
                default: ra = $urandom_range(1, 5);
            endcase
            run_txn(st, f3, a, $urandom, $urandom, ra);
        end
    endtask

    // Single compare process: expected per-cycle behaviour derived from the access length.
    always @(negedge clk) begin
        if (txn_active) begin
            if (stall) stall_cnt++;
            if (done) begin
                done_k     = k;
                last_load  = load_data;
                last_fault = fault;
            end
            if (k == 0) begin
                check_output("issue_stall", 32'(stall), 32'd1);
                check_output("issue_done", 32'(done), 32'd0);
                check_output("issue_req", 32'(dmem_req), 32'd0);
            end else if (k <= n_busy) begin
                check_output("busy_stall", 32'(stall), 32'd1);
                check_output("busy_done", 32'(done), 32'd0);
                check_output("busy_req", 32'(dmem_req), 32'd1);
                check_output("busy_we", 32'(dmem_we), 32'(exp_st));
                check_output("busy_addr", dmem_addr, exp_addr);
                check_output("busy_be", 32'(dmem_be), 32'(exp_be));
                if (exp_st) check_output("busy_wdata", dmem_wdata, exp_wdata);
            end else begin
                check_output("retire_stall", 32'(stall), 32'd0);
                check_output("retire_done", 32'(done), 32'd1);
                check_output("retire_req", 32'(dmem_req), 32'd0);
                check_output("retire_fault", 32'(fault), 32'(exp_fault));
                check_output("retire_load", load_data, exp_load);
            end
        end else if (idle_chk) begin
            check_output("idle_stall", 32'(stall), 32'd0);
            check_output("idle_done", 32'(done), 32'd0);
            check_output("idle_req", 32'(dmem_req), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        m_bad;
        logic [3:0]  m_be;
        logic [31:0] m_wd;
        logic [31:0] m_ld;

        rst        = 1'b1;
        req_valid  = 1'b1;
        is_store   = 1'b0;
        funct3     = F3_W;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;

        model_eval(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF1234, m_bad, m_be, m_wd, m_ld);
        check_output("model_lb", m_ld, 32'hFFFFFF80);
        model_eval(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, m_bad, m_be, m_wd, m_ld);
        check_output("model_lbu", m_ld, 32'h00000080);
        model_eval(1'b0, F3_H, 32'h102, 32'h0, 32'h8001ABCD, m_bad, m_be, m_wd, m_ld);
        check_output("model_lh", m_ld, 32'hFFFF8001);
        model_eval(1'b1, F3_H, 32'h102, 32'h0000ABCD, 32'h0, m_bad, m_be, m_wd, m_ld);
        check_output("model_sh_be", 32'(m_be), 32'hC);
        check_output("model_sh_wdata", m_wd, 32'hABCDABCD);
        model_eval(1'b0, F3_W, 32'h101, 32'h0, 32'h0, m_bad, m_be, m_wd, m_ld);
        check_output("model_lw_misaligned", 32'(m_bad), 32'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_stall", 32'(stall), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_fault", 32'(fault), 32'd0);
        check_output("reset_req", 32'(dmem_req), 32'd0);
        check_output("reset_we", 32'(dmem_we), 32'd0);
        check_output("reset_load", load_data, 32'd0);
        check_output("reset_addr", dmem_addr, 32'd0);
        check_output("reset_wdata", dmem_wdata, 32'd0);
        check_output("reset_be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        idle_chk  = 1'b1;

        run_txn(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        check_output("sw_stall_cycles", 32'(stall_cnt), 32'd4);
        check_output("sw_done_cycle", 32'(done_k), 32'd4);

        run_txn(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF1234, 1);
        check_output("lb_result", last_load, 32'hFFFFFF80);
        check_output("min_latency_stall", 32'(stall_cnt), 32'd2);
        run_txn(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF1234, 2);
        check_output("lbu_result", last_load, 32'h00000080);
        run_txn(1'b0, F3_H, 32'h102, 32'h0, 32'h8001ABCD, 1);
        check_output("lh_result", last_load, 32'hFFFF8001);
        run_txn(1'b0, F3_HU, 32'h102, 32'h0, 32'h8001ABCD, 1);
        check_output("lhu_result", last_load, 32'h00008001);
        run_txn(1'b1, F3_H, 32'h102, 32'h0000ABCD, 32'h0, 2);

        run_txn(1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1);
        check_output("lw_misaligned_fault", 32'(last_fault), 32'd1);
        check_output("lw_misaligned_stall", 32'(stall_cnt), 32'd1);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        check_output("illegal_f3_fault", 32'(last_fault), 32'd1);

        run_txn(1'b0, F3_W, 32'h200, 32'h0, 32'h0, 0);
        check_output("timeout_fault", 32'(last_fault), 32'd1);
        check_output("timeout_stall", 32'(stall_cnt), 32'd17);
        run_txn(1'b0, F3_W, 32'h204, 32'h0, 32'h12345678, 16);
        check_output("last_cycle_ready_fault", 32'(last_fault), 32'd0);
        check_output("last_cycle_ready_load", last_load, 32'h12345678);

        // Reset lands on the second BUSY cycle of an in-flight load.
        idle_chk = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = F3_W;
        addr      = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_busy_stall", 32'(stall), 32'd0);
        check_output("rst_busy_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_output("after_rst_req", 32'(dmem_req), 32'd0);
        check_output("after_rst_stall", 32'(stall), 32'd0);
        idle_chk = 1'b1;
        repeat (3) @(posedge clk);
        run_txn(1'b1, F3_W, 32'h100, 32'hCAFEF00D, 32'h0, 1);
        check_output("post_rst_sw_fault", 32'(last_fault), 32'd0);

        apply_stimulus(80);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
